// File: rtl/tug_pkg.sv
// tug_pkg: shared FSM states, LED bounds and LED decode for the tug-of-war field
package tug_pkg;
  typedef enum logic [1:0] {PLAY, OUT_L, OUT_R} state_t;
  localparam logic [3:0] LED_CENTER = 4'd5;
  localparam logic [3:0] LED_MIN = 4'd1;
  localparam logic [3:0] LED_MAX = 4'd9;
  function automatic logic [8:0] led_bits(input logic [3:0] p);
    return 9'b1 << (p - 4'd1);
  endfunction
endpackage

// File: rtl/key_edge.sv
// key_edge: per-key rising-edge pulse, optional two-flop synchronizer under TUG_FIELD_SYNC_EN
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o
);
  logic k;
  logic prev_q;
`ifdef TUG_FIELD_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], key_i};
  assign k = sync_q[1];
`else
  assign k = key_i;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_q <= 1'b0;
    else prev_q <= k;
  assign press_o = k & ~prev_q;
endmodule

// File: rtl/tug_field.sv
// tug_field: tug-of-war light field; define TUG_FIELD_SYNC_EN to synchronize L/R before edge detection
module tug_field
  import tug_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic       restart,
  output logic [8:0] leds,
  output logic       game_over
);
  state_t state_q, state_d;
  logic [3:0] pos_q, pos_d;
  logic [8:0] leds_q, leds_d;
  logic go_q, go_d;
  logic pl, pr;
  key_edge u_l (.clk(clk), .rst_n(reset), .key_i(L), .press_o(pl));
  key_edge u_r (.clk(clk), .rst_n(reset), .key_i(R), .press_o(pr));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= PLAY;
      pos_q   <= LED_CENTER;
      leds_q  <= led_bits(LED_CENTER);
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      leds_q  <= leds_d;
      go_q    <= go_d;
    end
  // simultaneous presses cancel; restart overrides everything
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    if (restart) begin
      state_d = PLAY;
      pos_d   = LED_CENTER;
    end else if (state_q == PLAY && (pl ^ pr)) begin
      if (pr) begin
        state_d = pos_q == LED_MIN ? OUT_R : PLAY;
        pos_d   = pos_q == LED_MIN ? pos_q : pos_q - 4'd1;
      end else begin
        state_d = pos_q == LED_MAX ? OUT_L : PLAY;
        pos_d   = pos_q == LED_MAX ? pos_q : pos_q + 4'd1;
      end
    end
    leds_d = state_d == PLAY ? led_bits(pos_d) : 9'b0;
    go_d   = state_d != PLAY;
  end
  assign leds      = leds_q;
  assign game_over = go_q;
endmodule

// File: tb/tb_tug_field.sv
// tb_tug_field: vector table plus randomized run against a behavioural tug-of-war model
module tb_tug_field;
  logic clk = 1'b0;
  logic reset, L, R, restart;
  logic [8:0] leds;
  logic game_over;
  tug_field dut (.clk(clk), .reset(reset), .L(L), .R(R), .restart(restart), .leds(leds), .game_over(game_over));
  always #5 clk = ~clk;
`ifdef TUG_FIELD_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  typedef struct {bit l; bit r; bit rs; logic [8:0] leds; logic go;} vec_t;
  vec_t tbl[$];
  int n_cmp = 0, n_bad = 0;
  int m_pos;
  bit m_over, m_pl, m_pr, m_l1, m_l2, m_r1, m_r2;
  logic [8:0] rw[6] = '{9'h008, 9'h004, 9'h002, 9'h001, 9'h000, 9'h000};
  logic [8:0] lw[6] = '{9'h020, 9'h040, 9'h080, 9'h100, 9'h000, 9'h000};

  function automatic void model_reset();
    m_pos = 5; m_over = 0;
    m_pl = 0; m_pr = 0; m_l1 = 0; m_l2 = 0; m_r1 = 0; m_r2 = 0;
  endfunction

  function automatic void model_step(bit l, bit r, bit rs);
    bit el, er, pl, pr;
    el = LAT == 2 ? m_l2 : l;
    er = LAT == 2 ? m_r2 : r;
    pl = el && !m_pl;
    pr = er && !m_pr;
    m_pl = el; m_pr = er;
    m_l2 = m_l1; m_l1 = l; m_r2 = m_r1; m_r1 = r;
    if (rs) begin
      m_pos = 5; m_over = 0;
    end else if (!m_over && pl != pr) begin
      if (pr) begin
        if (m_pos == 1) m_over = 1; else m_pos--;
      end else begin
        if (m_pos == 9) m_over = 1; else m_pos++;
      end
    end
  endfunction

  function automatic logic [8:0] m_leds();
    return m_over ? 9'h0 : 9'(1 << (m_pos - 1));
  endfunction

  task automatic chk(string nm, logic [8:0] el, logic eg);
    n_cmp++;
    if (leds !== el || game_over !== eg) begin
      n_bad++;
      $display("FAIL %s: leds=%h game_over=%b, expected leds=%h game_over=%b", nm, leds, game_over, el, eg);
    end
  endtask

  task automatic cycle(bit l, bit r, bit rs);
    L = l; R = r; restart = rs;
    @(posedge clk);
    #1;
    model_step(l, r, rs);
  endtask

  task automatic add(bit l, bit r, bit rs, logic [8:0] e, logic g);
    tbl.push_back('{l, r, rs, e, g});
  endtask

  initial begin
    reset = 1'b0; L = 0; R = 0; restart = 0;
    model_reset();
    #12;
    chk("reset_state", 9'h010, 1'b0);
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0);
      chk("idle_after_reset", 9'h010, 1'b0);
    end
`ifndef TUG_FIELD_SYNC_EN
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 3; j++) add(0, 1, 0, rw[i], rw[i] == 9'h0);
      for (int j = 0; j < 2; j++) add(0, 0, 0, rw[i], rw[i] == 9'h0);
    end
    add(0, 0, 1, 9'h010, 0);
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 3; j++) add(1, 0, 0, lw[i], lw[i] == 9'h0);
      for (int j = 0; j < 2; j++) add(0, 0, 0, lw[i], lw[i] == 9'h0);
    end
    add(0, 0, 1, 9'h010, 0);
    add(1, 1, 0, 9'h010, 0);
    add(0, 0, 0, 9'h010, 0);
    for (int j = 0; j < 20; j++) add(0, 1, 0, 9'h008, 0);
    add(0, 0, 0, 9'h008, 0);
    add(0, 1, 0, 9'h004, 0);
    add(0, 0, 0, 9'h004, 0);
    add(0, 1, 1, 9'h010, 0);
    add(0, 0, 0, 9'h010, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].l, tbl[i].r, tbl[i].rs);
      chk($sformatf("vec%0d", i), tbl[i].leds, tbl[i].go);
    end
`else
    cycle(0, 1, 0);
    chk("sync_lat_e1", 9'h010, 1'b0);
    cycle(0, 0, 0);
    chk("sync_lat_e2", 9'h010, 1'b0);
    cycle(0, 0, 0);
    chk("sync_lat_e3", 9'h008, 1'b0);
    cycle(0, 0, 1);
    chk("sync_restart", 9'h010, 1'b0);
`endif
    cycle(1, 0, 0); cycle(0, 0, 0); cycle(1, 0, 0); cycle(0, 0, 0);
    cycle(0, 0, 0); cycle(0, 0, 0);
    chk("walk_to_7", 9'h040, 1'b0);
    #2 reset = 1'b0;
    #1 chk("async_reset_mid", 9'h010, 1'b0);
    model_reset();
    L = 1'b1;
    @(negedge clk) reset = 1'b1;
    cycle(1, 0, 0);
    chk("held_reset_m1", m_leds(), m_over);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0);
      chk("held_reset_m", m_leds(), m_over);
    end
    chk("held_across_reset", 9'h020, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0); cycle(0, 0, 0);
    end
    cycle(0, 0, 0); cycle(0, 0, 0);
    chk("out_left", 9'h000, 1'b1);
    cycle(0, 1, 0); cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    chk("out_ignores_keys", 9'h000, 1'b1);
    #2 reset = 1'b0;
    #1 chk("async_reset_out", 9'h010, 1'b0);
    model_reset();
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 30) == 0);
      chk("rand", m_leds(), m_over);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
